// File: rtl/tile_mover_sched.sv
// Tile-mover descriptor scheduler: round-robin intake from two requesters into a
// descriptor FIFO, then validate / issue / release / report against a level start/done mover.
module tile_mover_sched #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    input  logic [2*ADDR_WIDTH+23:0]  req0_desc,
    output logic                      req0_ready,
    input  logic                      req1_valid,
    input  logic [2*ADDR_WIDTH+23:0]  req1_desc,
    output logic                      req1_ready,
    output logic [ADDR_WIDTH-1:0]     src_base_addr,
    output logic [ADDR_WIDTH-1:0]     dst_base_addr,
    output logic [7:0]                b_dim,
    output logic [7:0]                w_dim,
    output logic [7:0]                c_dim,
    output logic                      start,
    input  logic                      done,
    output logic                      cmpl_valid,
    output logic                      cmpl_id,
    output logic                      cmpl_err,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    fifo_count
);
    // state   | meaning
    // IDLE    | waiting for work; pops FIFO head into the config register
    // CHECK   | one cycle to validate the latched dimensions
    // ISSUE   | start high, waiting for done to rise
    // RELEASE | start low, waiting for done to fall
    // REPORT  | one-cycle completion pulse
    typedef enum logic [2:0] {IDLE, CHECK, ISSUE, RELEASE, REPORT} state_t;

    localparam int DW = 2*ADDR_WIDTH + 24;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DW:0]     mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            rr_q;
    logic            live_q;
    state_t          state_q;
    logic [DW:0]     cfg_q;
    logic            start_q, cmpl_valid_q, cmpl_id_q, cmpl_err_q;

    logic            not_full, grant0, grant1, push, pop, cfg_bad;
    logic [DW:0]     push_entry;
    logic [7:0]      cfg_b, cfg_w, cfg_c;

    // rr_q high means requester 1 holds priority when both are valid.
    assign not_full   = (count_q != CW'(DEPTH));
    assign grant0     = req0_valid && (!req1_valid || !rr_q);
    assign grant1     = req1_valid && (!req0_valid || rr_q);
    assign req0_ready = live_q && not_full && grant0;
    assign req1_ready = live_q && not_full && grant1;
    assign push       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign push_entry = req1_ready ? {1'b1, req1_desc} : {1'b0, req0_desc};
    assign pop        = (state_q == IDLE) && (count_q != '0);

    assign cfg_b   = cfg_q[2*ADDR_WIDTH +: 8];
    assign cfg_w   = cfg_q[2*ADDR_WIDTH+8 +: 8];
    assign cfg_c   = cfg_q[2*ADDR_WIDTH+16 +: 8];
    assign cfg_bad = (cfg_b == 8'd0) || (cfg_w == 8'd0) || (cfg_c == 8'd0) || (cfg_c[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= 1'b0;
            live_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
                rr_q     <= !req1_ready;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            start_q      <= 1'b0;
            cmpl_valid_q <= 1'b0;
            cmpl_id_q    <= 1'b0;
            cmpl_err_q   <= 1'b0;
        end else begin
            cmpl_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        cfg_q   <= mem_q[rd_ptr_q];
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (cfg_bad) begin
                        state_q      <= REPORT;
                        cmpl_valid_q <= 1'b1;
                        cmpl_id_q    <= cfg_q[DW];
                        cmpl_err_q   <= 1'b1;
                    end else begin
                        state_q <= ISSUE;
                        start_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (done) begin
                        start_q <= 1'b0;
                        state_q <= RELEASE;
                    end
                end
                // Waiting for done low here keeps the next start off a stale done.
                RELEASE: begin
                    if (!done) begin
                        state_q      <= REPORT;
                        cmpl_valid_q <= 1'b1;
                        cmpl_id_q    <= cfg_q[DW];
                        cmpl_err_q   <= 1'b0;
                    end
                end
                REPORT:  state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign src_base_addr = cfg_q[ADDR_WIDTH-1:0];
    assign dst_base_addr = cfg_q[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign b_dim         = cfg_b;
    assign w_dim         = cfg_w;
    assign c_dim         = cfg_c;
    assign start         = start_q;
    assign cmpl_valid    = cmpl_valid_q;
    assign cmpl_id       = cmpl_id_q;
    assign cmpl_err      = cmpl_err_q;
    assign busy          = (state_q != IDLE) || (count_q != '0);
    assign fifo_count    = count_q;
endmodule
